// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the pattern playback block: state encoding,
// software register bit positions and status packing.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CTRL_CLR     = 0;
    localparam int CTRL_WR      = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_LOOP    = 3;
    localparam int CTRL_TRIG_EN = 4;

    localparam int ADDR_WADDR_LSB = 0;
    localparam int ADDR_LAST_LSB  = 8;

    localparam int STATUS_STATE_LSB    = 0;
    localparam int STATUS_WR_ERR       = 2;
    localparam int STATUS_RD_PTR_LSB   = 8;
    localparam int STATUS_LOOP_CNT_LSB = 16;

    localparam int LOOP_CNT_WIDTH = 8;

    function automatic logic [31:0] pack_status(
        input state_t                    st,
        input logic                      wr_err,
        input logic [7:0]                rd_ptr,
        input logic [LOOP_CNT_WIDTH-1:0] loop_cnt
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_STATE_LSB +: 2]                 = st;
        s[STATUS_WR_ERR]                         = wr_err;
        s[STATUS_RD_PTR_LSB +: 8]                = rd_ptr;
        s[STATUS_LOOP_CNT_LSB +: LOOP_CNT_WIDTH] = loop_cnt;
        return s;
    endfunction

endpackage

// File: rtl/pattern_mem64x64.sv
// Pattern storage: one write port, one registered read port, no reset on
// the array so it maps onto block RAM.
module pattern_mem64x64
    import pattern_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pattern_gen64x64.sv
// Stimulus playback engine: software-loaded pattern memory replayed one word
// per clock, one-shot or looping, optionally gated by an external trigger.
module pattern_gen64x64
    import pattern_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           sw_ctrl,
    input  logic [31:0]           sw_addr,
    input  logic [31:0]           sw_wdata_hi,
    input  logic [31:0]           sw_wdata_lo,
    input  logic                  trigger,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           status
);

    logic [1:0]                ctrl_q;
    logic                      clear;
    logic                      loop_en;
    logic                      trig_en;
    logic                      wr_pulse;
    logic                      start_pulse;
    logic                      idle_like;
    logic                      launch;
    logic                      mem_we;
    logic                      at_last;
    logic                      unused_inputs;

    state_t                    state;
    state_t                    state_next;
    logic [ADDR_WIDTH-1:0]     rd_ptr;
    logic [ADDR_WIDTH-1:0]     last;
    logic [LOOP_CNT_WIDTH-1:0] loop_cnt;
    logic                      wr_err;
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [31:0]               status_q;

    assign clear   = sw_ctrl[CTRL_CLR];
    assign loop_en = sw_ctrl[CTRL_LOOP];
    assign trig_en = sw_ctrl[CTRL_TRIG_EN];

    assign wr_pulse    = sw_ctrl[CTRL_WR]    & ~ctrl_q[0];
    assign start_pulse = sw_ctrl[CTRL_START] & ~ctrl_q[1];

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign launch    = ~clear & start_pulse & idle_like;
    assign mem_we    = wr_pulse & idle_like;
    assign at_last   = (rd_ptr == last);

    assign unused_inputs = ^{sw_ctrl, sw_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= sw_ctrl[CTRL_START:CTRL_WR];
        end
    end

    pattern_mem64x64 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (sw_addr[ADDR_WADDR_LSB +: ADDR_WIDTH]),
        .wr_data (DATA_WIDTH'({sw_wdata_hi, sw_wdata_lo})),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_pulse) begin
                        state_next = trig_en ? ST_ARMED : ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (at_last && !loop_en) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Pointer, loop counter, sticky error and the valid flag that tracks the
    // one-cycle read latency of the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            last     <= '0;
            loop_cnt <= '0;
            wr_err   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (clear) begin
            rd_ptr   <= '0;
            loop_cnt <= '0;
            wr_err   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state == ST_RUN);
            if (wr_pulse && !idle_like) begin
                wr_err <= 1'b1;
            end
            if (launch) begin
                rd_ptr   <= '0;
                loop_cnt <= '0;
                last     <= sw_addr[ADDR_LAST_LSB +: ADDR_WIDTH];
            end else if (state == ST_RUN) begin
                if (!at_last) begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end else if (loop_en) begin
                    rd_ptr <= '0;
                    if (loop_cnt != '1) begin
                        loop_cnt <= loop_cnt + LOOP_CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= pack_status(state, wr_err, 8'(rd_ptr), loop_cnt);
        end
    end

    // The RAM output register has no reset, so the word is gated by valid to
    // give a zero dout on reset, clear and idle cycles.
    assign dout       = valid_q ? rd_data : '0;
    assign dout_valid = valid_q;
    assign busy       = (state == ST_ARMED) || (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign status     = status_q;

endmodule

// File: tb/tb_pattern_gen64x64.sv
// Randomized bench for pattern_gen64x64: a word-array model of the pattern
// memory predicts each played word, done timing and loop counts.
module tb_pattern_gen64x64;

    localparam logic [31:0] C_CLR   = 32'h01;
    localparam logic [31:0] C_WR    = 32'h02;
    localparam logic [31:0] C_START = 32'h04;
    localparam logic [31:0] C_LOOP  = 32'h08;
    localparam logic [31:0] C_TRIG  = 32'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw_ctrl;
    logic [31:0] sw_addr;
    logic [31:0] sw_wdata_hi;
    logic [31:0] sw_wdata_lo;
    logic        trigger;
    logic [63:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        done;
    logic [31:0] status;

    logic [63:0] mem_model [0:63];
    int          checks;
    int          errors;

    pattern_gen64x64 #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_ctrl     (sw_ctrl),
        .sw_addr     (sw_addr),
        .sw_wdata_hi (sw_wdata_hi),
        .sw_wdata_lo (sw_wdata_lo),
        .trigger     (trigger),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .done        (done),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 ns after the capturing edge.
    task automatic applyStimulus(input logic [31:0] ctrl, input logic [31:0] addr,
                                 input logic [63:0] data, input logic trig);
        sw_ctrl     = ctrl;
        sw_addr     = addr;
        sw_wdata_hi = data[63:32];
        sw_wdata_lo = data[31:0];
        trigger     = trig;
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input int addr, input logic [63:0] data);
        applyStimulus(32'h0, 32'(addr), data, 1'b0);
        applyStimulus(C_WR, 32'(addr), data, 1'b0);
        mem_model[addr] = data;
    endtask

    task automatic checkOneShotWords(input int last);
        for (int e = 1; e <= last + 1; e++) begin
            applyStimulus(32'h0, 32'h0, 64'h0, 1'b0);
            checkOutput("os_valid", 64'(dout_valid), 64'd1);
            checkOutput("os_word", dout, mem_model[e-1]);
            checkOutput("os_done", 64'(done), 64'(e == last + 1));
        end
        applyStimulus(32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("os_valid_drop", 64'(dout_valid), 64'd0);
        checkOutput("os_done_hold", 64'(done), 64'd1);
        checkOutput("os_busy_low", 64'(busy), 64'd0);
        checkOutput("os_status_state", 64'(status[1:0]), 64'd3);
    endtask

    task automatic runOneShot(input int last);
        applyStimulus(C_START, 32'(last) << 8, 64'h0, 1'b0);
        checkOutput("os_busy", 64'(busy), 64'd1);
        checkOutput("os_first_valid", 64'(dout_valid), 64'd0);
        checkOneShotWords(last);
    endtask

    // drop_at < 0 keeps looping for 'cycles' edges and leaves the run active;
    // otherwise loop is held through edge drop_at and the pass is completed.
    task automatic runLoop(input int last, input int cycles, input int drop_at);
        int n;
        int end_e;
        int lc;
        n = last + 1;
        applyStimulus(C_START | C_LOOP, 32'(last) << 8, 64'h0, 1'b0);
        checkOutput("loop_busy", 64'(busy), 64'd1);
        if (drop_at >= 0) begin
            end_e = drop_at + 1;
            while ((end_e - 1) % n != last) end_e++;
        end else begin
            end_e = cycles;
        end
        for (int e = 1; e <= end_e; e++) begin
            applyStimulus((drop_at < 0 || e <= drop_at) ? C_LOOP : 32'h0, 32'h0, 64'h0, 1'b0);
            lc = (e - 1) / n;
            if (lc > 255) lc = 255;
            checkOutput("loop_valid", 64'(dout_valid), 64'd1);
            checkOutput("loop_word", dout, mem_model[(e-1) % n]);
            checkOutput("loop_cnt", 64'(status[23:16]), 64'(lc));
            checkOutput("loop_rd_ptr", 64'(status[15:8]), 64'((e - 1) % n));
            if (drop_at >= 0) checkOutput("loop_done", 64'(done), 64'(e == end_e));
        end
        if (drop_at >= 0) begin
            applyStimulus(32'h0, 32'h0, 64'h0, 1'b0);
            checkOutput("loop_end_valid", 64'(dout_valid), 64'd0);
            checkOutput("loop_end_done", 64'(done), 64'd1);
        end
    endtask

    task automatic doClear();
        applyStimulus(C_CLR, 32'h0, 64'h0, 1'b0);
        checkOutput("clr_valid", 64'(dout_valid), 64'd0);
        checkOutput("clr_dout", dout, 64'd0);
        checkOutput("clr_busy", 64'(busy), 64'd0);
        checkOutput("clr_done", 64'(done), 64'd0);
        applyStimulus(C_CLR, 32'h0, 64'h0, 1'b0);
        checkOutput("clr_status", 64'(status), 64'd0);
        applyStimulus(32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("clr_idle", 64'(busy | done | dout_valid), 64'd0);
    endtask

    task automatic runTriggered(input int last, input int wait_n);
        applyStimulus(C_START | C_TRIG, 32'(last) << 8, 64'h0, 1'b0);
        checkOutput("arm_busy", 64'(busy), 64'd1);
        checkOutput("arm_valid", 64'(dout_valid), 64'd0);
        for (int w = 0; w < wait_n; w++) begin
            applyStimulus(C_TRIG, 32'(last) << 8, 64'h0, 1'b0);
            checkOutput("arm_wait_valid", 64'(dout_valid), 64'd0);
            checkOutput("arm_wait_state", 64'(status[1:0]), 64'd1);
        end
        applyStimulus(C_TRIG, 32'(last) << 8, 64'h0, 1'b1);
        checkOutput("trig_no_word_yet", 64'(dout_valid), 64'd0);
        checkOutput("trig_busy", 64'(busy), 64'd1);
        checkOneShotWords(last);
    endtask

    task automatic runWriteWhileRun(input int last);
        int waddr;
        waddr = $urandom_range(0, last);
        applyStimulus(C_START | C_LOOP, 32'(last) << 8, 64'h0, 1'b0);
        applyStimulus(C_LOOP, 32'h0, 64'h0, 1'b0);
        applyStimulus(C_LOOP | C_WR, 32'(waddr), ~mem_model[waddr], 1'b0);
        applyStimulus(C_LOOP, 32'h0, 64'h0, 1'b0);
        checkOutput("wr_err_set", 64'(status[2]), 64'd1);
        checkOutput("wr_err_busy", 64'(busy), 64'd1);
        doClear();
        checkOutput("wr_err_cleared", 64'(status[2]), 64'd0);
        runOneShot(last);
    endtask

    task automatic runStartWithWrite(input int last, input logic [63:0] data);
        applyStimulus(C_START | C_WR, 32'(last) << 8, data, 1'b0);
        mem_model[0] = data;
        checkOutput("sw_busy", 64'(busy), 64'd1);
        checkOneShotWords(last);
    endtask

    initial begin
        int last_r;
        int mode;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        sw_ctrl     = '0;
        sw_addr     = '0;
        sw_wdata_hi = '0;
        sw_wdata_lo = '0;
        trigger     = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_dout", dout, 64'd0);
        checkOutput("rst_valid", 64'(dout_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_status", 64'(status), 64'd0);
        #2 rst_n = 1'b1;

        applyStimulus(32'h0, 32'h0, 64'h0, 1'b1);
        checkOutput("trig_ignored_idle", 64'(busy), 64'd0);

        writeWord(0, 64'h1111_1111_1111_1111);
        writeWord(1, 64'h2222_2222_2222_2222);
        writeWord(2, 64'h3333_3333_3333_3333);
        writeWord(3, 64'h4444_4444_4444_4444);
        runOneShot(3);
        runLoop(3, 10, -1);
        doClear();

        for (int a = 0; a < 64; a++) writeWord(a, {$urandom, $urandom});

        for (int r = 0; r < 6; r++) begin
            last_r = $urandom_range(0, 63);
            mode   = $urandom_range(0, 2);
            case (mode)
                0: runOneShot(last_r);
                1: begin
                    runLoop(last_r, $urandom_range(1, 150), -1);
                    doClear();
                end
                default: runLoop(last_r, 0, $urandom_range(0, 2 * last_r + 2));
            endcase
        end

        runOneShot(0);
        runLoop(0, 300, -1);
        doClear();

        applyStimulus(32'h0, 32'h0, 64'h0, 1'b1);
        runTriggered($urandom_range(0, 63), $urandom_range(1, 5));
        runWriteWhileRun($urandom_range(1, 63));
        runStartWithWrite($urandom_range(0, 63), {$urandom, $urandom});

        runLoop($urandom_range(2, 63), 5, -1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_dout", dout, 64'd0);
        checkOutput("arst_valid", 64'(dout_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_status", 64'(status), 64'd0);
        sw_ctrl = '0;
        #2 rst_n = 1'b1;
        applyStimulus(32'h0, 32'h0, 64'h0, 1'b0);
        checkOutput("arst_idle_status", 64'(status), 64'd0);
        checkOutput("arst_idle_busy", 64'(busy | done), 64'd0);
        runOneShot($urandom_range(0, 63));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
